// File: rtl/if_pipe_ctrl.sv
// if_pipe_ctrl
//   Pipeline sequencing controller for the five-stage MIPS core. Sits beside
//   the IF stage and generates PC-update, IF/ID load/flush and ID/EX bubble
//   controls. Detects load-use and branch-operand hazards, prioritises
//   jump over taken branch, and runs an IDLE/RUN/STALL2/HALT state machine.
//   Keeps saturating stall and flush performance counters.
//
// Ports
//   clk           in   pipeline clock, rising edge
//   reset         in   asynchronous active-low reset
//   start         in   leave IDLE/HALT, enter RUN
//   halt_req      in   freeze request, honoured in RUN
//   instr_id      in   [31:0] instruction in ID
//   branch_taken  in   ID comparator result for beq/bne
//   jump_id       in   ID instruction is j/jal
//   ex_reg_write  in   EX instruction writes the register file
//   ex_mem_read   in   EX instruction is a load
//   ex_dst        in   [4:0] EX destination register
//   mem_mem_read  in   MEM instruction is a load
//   mem_dst       in   [4:0] MEM destination register
//   pc_write      out  PC update enable
//   pc_sel        out  [1:0] 00 PC+4, 01 branch target, 10 jump target
//   ifid_write    out  IF/ID load enable
//   ifid_flush    out  load IF/ID with a nop
//   idex_bubble   out  zero ID/EX control fields
//   state         out  [1:0] 00 IDLE, 01 RUN, 10 STALL2, 11 HALT
//   stall_cnt     out  [CNT_W-1:0] bubble-insert cycle count (saturating)
//   flush_cnt     out  [CNT_W-1:0] flush cycle count (saturating)
module if_pipe_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_req,
  input  logic [31:0]      instr_id,
  input  logic             branch_taken,
  input  logic             jump_id,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_dst,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_dst,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_STALL2 = 2'b10,
    S_HALT   = 2'b11
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [5:0] w_op;
  logic [4:0] w_rs;
  logic [4:0] w_rt;
  logic       w_reads_rt;
  logic       w_is_br;
  logic       w_load_use;
  logic       w_br_alu;
  logic       w_br_memld;
  logic       w_stall;
  logic       w_stall_cyc;
  logic       w_unused_bits;

  // Counter increment that holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // $0 is hard-wired zero, so a write to it never creates a dependency.
  function automatic logic src_hit(input logic [4:0] d, input logic [4:0] rs,
                                   input logic [4:0] rt, input logic rd_rt);
    return (d != 5'd0) && ((d == rs) || (rd_rt && (d == rt)));
  endfunction

  assign w_op          = instr_id[31:26];
  assign w_rs          = instr_id[25:21];
  assign w_rt          = instr_id[20:16];
  assign w_unused_bits = ^instr_id[15:0];

  // rt is a source only for R-type, beq, bne and sw.
  assign w_reads_rt = (w_op == 6'h00) || (w_op == 6'h04) ||
                      (w_op == 6'h05) || (w_op == 6'h2B);
  assign w_is_br    = (w_op == 6'h04) || (w_op == 6'h05);

  assign w_load_use = ex_mem_read & src_hit(ex_dst, w_rs, w_rt, w_reads_rt);
  // Branches resolve in ID, so an ALU result still in EX is not yet
  // forwardable to the comparator; a load in MEM is not either.
  assign w_br_alu   = w_is_br & ex_reg_write & ~ex_mem_read &
                      src_hit(ex_dst, w_rs, w_rt, w_reads_rt);
  assign w_br_memld = w_is_br & mem_mem_read &
                      src_hit(mem_dst, w_rs, w_rt, w_reads_rt);
  assign w_stall    = w_load_use | w_br_alu | w_br_memld;

  // Next-state and output decode
  always_comb begin
    w_state_nxt = r_state;
    pc_write    = 1'b0;
    pc_sel      = 2'b00;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b1;
    case (r_state)
      S_IDLE, S_HALT: begin
        if (start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!w_stall) begin
          pc_write    = 1'b1;
          idex_bubble = 1'b0;
          if (jump_id) begin
            pc_sel     = 2'b10;
            ifid_flush = 1'b1;
          end else if (w_is_br && branch_taken) begin
            pc_sel     = 2'b01;
            ifid_flush = 1'b1;
          end else begin
            ifid_write = 1'b1;
          end
        end
        // A branch waiting on a load in EX needs a second bubble, but a
        // pending halt overrides that.
        if (halt_req)                     w_state_nxt = S_HALT;
        else if (w_is_br && w_load_use)   w_state_nxt = S_STALL2;
      end
      S_STALL2: begin
        w_state_nxt = S_RUN;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_stall_cyc = ((r_state == S_RUN) && w_stall) || (r_state == S_STALL2);

  // State and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_stall_cyc) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (ifid_flush)  r_flush_cnt <= sat_inc(r_flush_cnt);
    end
  end

  assign state     = r_state;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_if_pipe_ctrl.sv
// Testbench for if_pipe_ctrl: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_if_pipe_ctrl;

  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             start, halt_req;
  logic [31:0]      instr_id;
  logic             branch_taken, jump_id;
  logic             ex_reg_write, ex_mem_read;
  logic [4:0]       ex_dst;
  logic             mem_mem_read;
  logic [4:0]       mem_dst;
  logic             pc_write;
  logic [1:0]       pc_sel;
  logic             ifid_write, ifid_flush, idex_bubble;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  if_pipe_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
    .instr_id(instr_id), .branch_taken(branch_taken), .jump_id(jump_id),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_dst(ex_dst),
    .mem_mem_read(mem_mem_read), .mem_dst(mem_dst),
    .pc_write(pc_write), .pc_sel(pc_sel), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Model state: 0 IDLE, 1 RUN, 2 second branch bubble, 3 HALT.
  int m_st, m_sc, m_fc;

  function automatic bit depends_on(input logic [31:0] ins, input logic [4:0] d);
    logic [5:0] op;
    op = ins[31:26];
    if (d == 5'd0) return 1'b0;
    if (d == ins[25:21]) return 1'b1;
    return (op inside {6'h00, 6'h04, 6'h05, 6'h2B}) && (d == ins[20:16]);
  endfunction

  // Expected outputs and next model state from the current inputs.
  function automatic void model(input int st, output bit pw, output int ps,
                                output bit iw, output bit fl, output bit bub,
                                output bit cnt_stall, output int nst);
    bit br, lu, hz;
    br = (instr_id[31:26] == 6'h04) || (instr_id[31:26] == 6'h05);
    lu = ex_mem_read && depends_on(instr_id, ex_dst);
    hz = lu || (br && ex_reg_write && !ex_mem_read && depends_on(instr_id, ex_dst))
            || (br && mem_mem_read && depends_on(instr_id, mem_dst));
    pw = 0; ps = 0; iw = 0; fl = 0; bub = 1; cnt_stall = 0; nst = st;
    if (st == 0 || st == 3) begin
      if (start) nst = 1;
    end else if (st == 2) begin
      cnt_stall = 1; nst = 1;
    end else begin
      if (hz) cnt_stall = 1;
      else begin
        pw = 1; bub = 0;
        if (jump_id)                 begin ps = 2; fl = 1; end
        else if (br && branch_taken) begin ps = 1; fl = 1; end
        else iw = 1;
      end
      nst = halt_req ? 3 : ((br && lu) ? 2 : 1);
    end
  endfunction

  always @(posedge clk or negedge reset) begin
    bit pw, iw, fl, bub, cs; int ps, nst;
    if (!reset) begin
      m_st <= 0; m_sc <= 0; m_fc <= 0;
    end else begin
      model(m_st, pw, ps, iw, fl, bub, cs, nst);
      if (cs && m_sc < CMAX) m_sc <= m_sc + 1;
      if (fl && m_fc < CMAX) m_fc <= m_fc + 1;
      m_st <= nst;
    end
  end

  always @(negedge clk) begin
    bit pw, iw, fl, bub, cs; int ps, nst;
    if (cmp_on) begin
      model(m_st, pw, ps, iw, fl, bub, cs, nst);
      chk("m_state", state, m_st);
      chk("m_pc_write", pc_write, pw);
      chk("m_pc_sel", pc_sel, ps);
      chk("m_ifid_write", ifid_write, iw);
      chk("m_ifid_flush", ifid_flush, fl);
      chk("m_idex_bubble", idex_bubble, bub);
      chk("m_stall_cnt", stall_cnt, m_sc);
      chk("m_flush_cnt", flush_cnt, m_fc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_in();
    start = 0; halt_req = 0; instr_id = 32'h0; branch_taken = 0; jump_id = 0;
    ex_reg_write = 0; ex_mem_read = 0; ex_dst = 0; mem_mem_read = 0; mem_dst = 0;
  endtask

  // Called just after a rising edge: pulse reset, then start for one cycle.
  task automatic reset_and_start();
    reset = 0; #2; reset = 1;
    start = 1; tick(); start = 0;
  endtask

  logic [31:0] add_s2, bne_t1, beq_00;

  initial begin
    add_s2 = {6'h00, 5'd18, 5'd17, 5'd18, 5'd0, 6'h20};
    bne_t1 = {6'h05, 5'd9, 5'd16, 16'h0010};
    beq_00 = {6'h04, 5'd0, 5'd0, 16'h0004};
    clear_in();
    reset = 0;
    #3;
    chk("rst_state", state, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    chk("rst_pc_write", pc_write, 0);
    chk("rst_bubble", idex_bubble, 1);
    tick();
    reset = 1;
    cmp_on = 1;

    // start for one cycle
    start = 1;
    @(negedge clk); chk("idle_state", state, 0);
    tick(); start = 0;
    @(negedge clk);
    chk("run_state", state, 1);
    chk("run_pc_write", pc_write, 1);
    chk("run_pc_sel", pc_sel, 0);
    chk("run_stall_cnt", stall_cnt, 0);

    // load-use: lw $s1 in EX, add $s2,$s2,$s1 in ID
    tick();
    instr_id = add_s2; ex_mem_read = 1; ex_reg_write = 1; ex_dst = 17;
    @(negedge clk);
    chk("lu_pc_write", pc_write, 0);
    chk("lu_bubble", idex_bubble, 1);
    tick(); clear_in(); instr_id = add_s2;
    @(negedge clk);
    chk("lu_after_pc_write", pc_write, 1);
    chk("lu_stall_cnt", stall_cnt, 1);
    chk("lu_state", state, 1);

    // bne $t1,$s0 with lw $t1 ahead: two frozen cycles, then taken
    tick(); clear_in(); reset_and_start();
    instr_id = bne_t1; ex_mem_read = 1; ex_reg_write = 1; ex_dst = 9;
    @(negedge clk);
    chk("brld1_state", state, 1);
    chk("brld1_pc_write", pc_write, 0);
    chk("brld1_flush", ifid_flush, 0);
    tick();
    ex_mem_read = 0; ex_reg_write = 0; mem_mem_read = 1; mem_dst = 9; branch_taken = 1;
    @(negedge clk);
    chk("brld2_state", state, 2);
    chk("brld2_pc_write", pc_write, 0);
    chk("brld2_pc_sel", pc_sel, 0);
    chk("brld2_flush", ifid_flush, 0);
    tick(); mem_mem_read = 0;
    @(negedge clk);
    chk("brtk_state", state, 1);
    chk("brtk_pc_sel", pc_sel, 1);
    chk("brtk_flush", ifid_flush, 1);
    chk("brtk_ifid_write", ifid_write, 0);
    tick(); clear_in();
    @(negedge clk);
    chk("brld_stall_cnt", stall_cnt, 2);
    chk("brld_flush_cnt", flush_cnt, 1);

    // jump and taken branch together: jump wins
    tick(); instr_id = beq_00; branch_taken = 1; jump_id = 1;
    @(negedge clk);
    chk("jmp_pc_sel", pc_sel, 2);
    chk("jmp_flush", ifid_flush, 1);
    chk("jmp_pc_write", pc_write, 1);

    // halt_req in RUN
    tick(); clear_in(); halt_req = 1;
    @(negedge clk); chk("halt_run_pc_write", pc_write, 1);
    tick(); halt_req = 0;
    @(negedge clk);
    chk("halt_state", state, 3);
    chk("halt_pc_write", pc_write, 0);
    tick(); start = 1;
    tick(); start = 0;
    @(negedge clk); chk("unhalt_state", state, 1);

    // halt_req together with a branch-on-load stall: HALT beats STALL2
    tick(); instr_id = bne_t1; ex_mem_read = 1; ex_dst = 9; halt_req = 1;
    @(negedge clk); chk("halt_stall_pc_write", pc_write, 0);
    tick(); clear_in();
    @(negedge clk); chk("halt_stall_state", state, 3);
    tick(); start = 1; tick(); start = 0;

    // reset dropped mid-STALL2
    instr_id = bne_t1; ex_mem_read = 1; ex_dst = 9;
    tick(); clear_in();
    @(negedge clk); chk("pre_rst_state", state, 2);
    #1 reset = 0; start = 1;
    #1;
    chk("arst_state", state, 0);
    chk("arst_stall_cnt", stall_cnt, 0);
    chk("arst_pc_write", pc_write, 0);
    chk("arst_bubble", idex_bubble, 1);
    tick();
    chk("arst_start_ignored", state, 0);
    reset = 1; start = 0;
    start = 1; tick(); start = 0;

    // saturation of stall_cnt under a held load-use hazard
    instr_id = add_s2; ex_mem_read = 1; ex_dst = 17;
    repeat (CMAX + 4) tick();
    @(negedge clk);
    chk("sat_stall_cnt", stall_cnt, CMAX);
    chk("sat_state", state, 1);
    tick(); clear_in();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] op;
      logic [4:0] rs, rt;
      case ($urandom_range(0, 6))
        0: op = 6'h00;
        1: op = 6'h04;
        2: op = 6'h05;
        3: op = 6'h2B;
        4: op = 6'h23;
        5: op = 6'h02;
        default: op = 6'($urandom);
      endcase
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      instr_id     = {op, rs, rt, 16'($urandom)};
      branch_taken = 1'($urandom);
      jump_id      = ($urandom_range(0, 5) == 0);
      ex_reg_write = 1'($urandom);
      ex_mem_read  = 1'($urandom);
      mem_mem_read = 1'($urandom);
      case ($urandom_range(0, 2))
        0: ex_dst = rs;
        1: ex_dst = rt;
        default: ex_dst = 5'($urandom_range(0, 7));
      endcase
      mem_dst  = ($urandom_range(0, 1) == 0) ? rs : 5'($urandom_range(0, 7));
      start    = ($urandom_range(0, 7) == 0);
      halt_req = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 199) == 0) begin
        reset = 0; #2; reset = 1;
      end
      tick();
    end

    clear_in();
    tick();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_pipe_ctrl.md
# if_pipe_ctrl

Pipeline sequencing controller for the five-stage MIPS core. It sits beside the instruction-fetch stage and drives that stage's PC-update, IF/ID-register and flush controls, plus the ID/EX bubble insert. It detects load-use and branch-operand hazards, resolves jump and branch redirect priority, and runs a start/run/halt state machine. It also keeps saturating performance counters for stalls and flushes.

## Interface

Parameters:
- CNT_W, 16, width of the performance counters

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately
- start  input  1  leave IDLE or HALT and enter RUN
- halt_req  input  1  request to freeze the front end; sampled in RUN
- instr_id  input  32  instruction currently in ID (IF/ID register contents)
- branch_taken  input  1  ID-stage comparator result for beq/bne in ID
- jump_id  input  1  ID instruction is j/jal
- ex_reg_write  input  1  instruction in EX writes the register file
- ex_mem_read  input  1  instruction in EX is a load
- ex_dst  input  5  destination register of the EX instruction
- mem_mem_read  input  1  instruction in MEM is a load
- mem_dst  input  5  destination register of the MEM instruction
- pc_write  output  1  PC register update enable
- pc_sel  output  2  next-PC select: 00 PC+4, 01 branch target, 10 jump target; 11 is never driven
- ifid_write  output  1  IF/ID register load enable
- ifid_flush  output  1  load IF/ID with 32'd0 (nop)
- idex_bubble  output  1  zero ID/EX control fields
- state  output  2  00 IDLE, 01 RUN, 10 STALL2, 11 HALT
- stall_cnt  output  CNT_W  cycles in which the controller inserted a bubble
- flush_cnt  output  CNT_W  cycles in which the controller asserted ifid_flush

## Operation

- Field decode from instr_id: rs=[25:21], rt=[20:16], op=[31:26].
- The instruction reads rt when op is 0x00 (R-type), 0x04 (beq), 0x05 (bne) or 0x2B (sw).
- is_br is true when op is 0x04 or 0x05.
- Register $0 never matches in any hazard comparison.
- src_hit(d) is true when d≠0 and (d==rs, or (d==rt and the instruction reads rt)).

Hazard terms:
- load_use = ex_mem_read & src_hit(ex_dst).
- br_alu = is_br & ex_reg_write & ~ex_mem_read & src_hit(ex_dst).
- br_memld = is_br & mem_mem_read & src_hit(mem_dst).
- stall = load_use | br_alu | br_memld.

States:
- IDLE (reset state): pc_write=0, ifid_write=0, idex_bubble=1, pc_sel=00. Go to RUN when start=1.
- RUN, per cycle, in priority order:
  - halt_req: this cycle behaves as normal RUN, then go to HALT.
  - stall: pc_write=0, ifid_write=0, idex_bubble=1, redirect suppressed. If is_br & load_use, go to STALL2; otherwise stay in RUN.
  - jump_id: pc_sel=10, ifid_flush=1.
  - is_br & branch_taken: pc_sel=01, ifid_flush=1.
  - otherwise: pc_sel=00, pc_write=1, ifid_write=1.
- STALL2 (second bubble for a branch whose operand is a load two stages ahead):
  - Freeze exactly as in the stall row.
  - Next state is unconditionally RUN; hazards are re-evaluated there.
- HALT: same outputs as IDLE. Go to RUN when start=1. halt_req is ignored in this state.
- In RUN with no stall, pc_write=1 and idex_bubble=0. ifid_write=1 unless a flush is asserted, which wins over ifid_write.
- halt_req and stall in the same cycle: the stall outputs apply, and the next state is HALT. Halt takes precedence over STALL2.
- Counters:
  - stall_cnt increments in every RUN-with-stall or STALL2 cycle.
  - flush_cnt increments in every cycle with ifid_flush=1.
  - Both saturate at all-ones and never wrap.

## Timing

- All outputs are combinational from the registered state and the current inputs. There are no registered outputs except state and the counters.
- The redirect takes effect at the next rising edge: the PC loads the target and IF/ID loads the nop in the same edge. Cost is 1 bubble per taken branch or jump.
- Load-use costs 1 stall cycle. A branch on an ALU result costs 1 cycle. A branch on a load costs 2 cycles (RUN-stall followed by STALL2).
- state and counters update on the rising clk edge.
- reset low at any time: state=IDLE and both counters=0 immediately. Outputs take the IDLE values without waiting for a clock.
- While reset is low, start is ignored.

## Test plan

- Reset, then start=1 for one cycle: state 00→01, pc_write=1, pc_sel=00, all counters 0.
- Load-use: lw $s1 in EX (ex_mem_read=1, ex_dst=17), ID = add $s2,$s2,$s1. Required: exactly 1 cycle with pc_write=0, idex_bubble=1; stall_cnt=1.
- bne $t1,$s0 in ID with lw $t1 in EX (ex_dst=9). Required: 2 frozen cycles (state 01 then 10), no redirect during them. Then with branch_taken=1: pc_sel=01, ifid_flush=1; stall_cnt=2, flush_cnt=1.
- jump_id=1 and is_br&branch_taken in the same cycle, no hazard: pc_sel=10, ifid_flush=1.
- halt_req in RUN: state 11 next cycle, pc_write=0; start=1 returns state to 01. Drop reset mid-STALL2: state 00 asynchronously.
- Hold a load-use hazard for 2^CNT_W+3 cycles: stall_cnt stops at all-ones and does not wrap.
